// File: rtl/systolic_feeder.sv
// Skew sequencer feeding a NxN systolic array: loads A/B row by row, emits diagonal wavefronts, then flags result.
// Optional macro SA_FEEDER_AUTOCLR_EN: pulse arr_clr once after the result handshake.
module systolic_feeder #(
  parameter int N     = 4,
  parameter int DW    = 16,
  parameter int DRAIN = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N*DW-1:0] in_a_row,
  input  logic [N*DW-1:0] in_b_row,
  output logic [N*DW-1:0] a_out,
  output logic [N*DW-1:0] b_out,
  output logic          busy,
  output logic          res_valid,
  input  logic          res_ack,
  output logic          arr_clr
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(2*N + DRAIN + 1);

  typedef enum logic [1:0] {S_LOAD, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [RW-1:0]   row_q;
  logic [CW-1:0]   cnt_q, cnt_nxt;
  logic [CW-1:0]   step_nxt;
  logic            wave_en;
  logic            accept, last_beat;
  logic [DW-1:0]   a_mem [N][N];
  logic [DW-1:0]   b_mem [N][N];
  logic [N*DW-1:0] a_nxt, b_nxt;

  assign in_ready  = (state == S_LOAD);
  assign busy      = (state == S_FEED) || (state == S_DRAIN);
  assign res_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign last_beat = (row_q == RW'(N-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LOAD;
      cnt_q <= '0;
      row_q <= '0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
      if (accept)
        row_q <= last_beat ? '0 : row_q + RW'(1);
    end
  end

  // Step counter is shared between FEED (step) and DRAIN (idle count).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    wave_en   = 1'b0;
    step_nxt  = '0;
    case (state)
      S_LOAD: begin
        if (accept && last_beat) begin
          state_nxt = S_FEED;
          cnt_nxt   = '0;
          wave_en   = 1'b1;
        end
      end
      S_FEED: begin
        if (cnt_q == CW'(2*N-1)) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt  = cnt_q + CW'(1);
          wave_en  = 1'b1;
          step_nxt = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(DRAIN-1)) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (res_ack)
          state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < N; c++) begin
        a_mem[row_q][RW'(c)] <= in_a_row[c*DW +: DW];
        b_mem[row_q][RW'(c)] <= in_b_row[c*DW +: DW];
      end
    end
  end

  // Step 0 is computed on the same edge that writes the last row, so that row is bypassed from the input.
  always_comb begin
    int ra, cb;
    ra    = 0;
    cb    = 0;
    a_nxt = '0;
    b_nxt = '0;
    for (int j = 0; j < N; j++) begin
      ra = j + N - 1 - int'(step_nxt);
      if (wave_en && ra >= 0 && ra < N) begin
        if (accept && row_q == RW'(ra))
          a_nxt[j*DW +: DW] = in_a_row[j*DW +: DW];
        else
          a_nxt[j*DW +: DW] = a_mem[RW'(ra)][RW'(j)];
      end
      cb = j + N - 1 - int'(step_nxt);
      if (wave_en && cb >= 0 && cb < N) begin
        if (accept && row_q == RW'(j))
          b_nxt[j*DW +: DW] = in_b_row[cb*DW +: DW];
        else
          b_nxt[j*DW +: DW] = b_mem[RW'(j)][RW'(cb)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
    end else begin
      a_out <= a_nxt;
      b_out <= b_nxt;
    end
  end

`ifdef SA_FEEDER_AUTOCLR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      arr_clr <= 1'b0;
    else
      arr_clr <= (state == S_DONE) && res_ack;
  end
`else
  assign arr_clr = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed, table-driven bench for systolic_feeder (N=4, DW=16, DRAIN=4).
module tb_systolic_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_a_row = '0;
  logic [63:0] in_b_row = '0;
  logic [63:0] a_out, b_out;
  logic        busy, res_valid, arr_clr;
  logic        res_ack = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  systolic_feeder #(.N(4), .DW(16), .DRAIN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a_row(in_a_row), .in_b_row(in_b_row), .a_out(a_out), .b_out(b_out),
    .busy(busy), .res_valid(res_valid), .res_ack(res_ack), .arr_clr(arr_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a[4];
    int b[4];
  } vec_t;

  vec_t tbl[13];
  int   gaps[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ex(input int v, input int off);
    return (v == 0) ? 0 : v + off;
  endfunction

  function automatic logic [63:0] pk(input int v0, input int v1, input int v2, input int v3);
    return {v3[15:0], v2[15:0], v1[15:0], v0[15:0]};
  endfunction

  // Element (r,c) of the loaded matrix is 4r+c+1+off; gap[k] idle cycles precede beat k.
  task automatic load_mat(input int aoff, input int boff, input int gap[4]);
    for (int r = 0; r < 4; r++) begin
      for (int g = 0; g < gap[r]; g++) begin
        in_valid = 1'b0;
        @(negedge clk);
        chk("gap_rdy", {63'd0, in_ready}, 64'd1);
      end
      chk("ld_rdy", {63'd0, in_ready}, 64'd1);
      chk("ld_busy", {63'd0, busy}, 64'd0);
      in_a_row = pk(4*r+1+aoff, 4*r+2+aoff, 4*r+3+aoff, 4*r+4+aoff);
      in_b_row = pk(4*r+1+boff, 4*r+2+boff, 4*r+3+boff, 4*r+4+boff);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Entered at the negedge of step 0; leaves at the negedge of the first res_valid cycle.
  task automatic run_table(input int aoff, input int boff);
    for (int k = 0; k < 13; k++) begin
      chk($sformatf("a_out[%0d]", k), a_out,
          pk(ex(tbl[k].a[0], aoff), ex(tbl[k].a[1], aoff), ex(tbl[k].a[2], aoff), ex(tbl[k].a[3], aoff)));
      chk($sformatf("b_out[%0d]", k), b_out,
          pk(ex(tbl[k].b[0], boff), ex(tbl[k].b[1], boff), ex(tbl[k].b[2], boff), ex(tbl[k].b[3], boff)));
      chk($sformatf("busy[%0d]", k), {63'd0, busy}, {63'd0, (k < 12)});
      chk($sformatf("res_valid[%0d]", k), {63'd0, res_valid}, {63'd0, (k == 12)});
      chk($sformatf("in_ready[%0d]", k), {63'd0, in_ready}, {63'd0, (k == 12) ? 1'b0 : 1'b0});
      if (k < 12) @(negedge clk);
    end
  endtask

  task automatic check_ack_result;
    logic exp_clr;
`ifdef SA_FEEDER_AUTOCLR_EN
    exp_clr = 1'b1;
`else
    exp_clr = 1'b0;
`endif
    chk("ack_res_valid", {63'd0, res_valid}, 64'd0);
    chk("ack_in_ready", {63'd0, in_ready}, 64'd1);
    chk("ack_arr_clr", {63'd0, arr_clr}, {63'd0, exp_clr});
    @(negedge clk);
    chk("arr_clr_once", {63'd0, arr_clr}, 64'd0);
  endtask

  initial begin
    tbl[0]  = '{a: '{13, 0, 0, 0},   b: '{4, 0, 0, 0}};
    tbl[1]  = '{a: '{9, 14, 0, 0},   b: '{3, 8, 0, 0}};
    tbl[2]  = '{a: '{5, 10, 15, 0},  b: '{2, 7, 12, 0}};
    tbl[3]  = '{a: '{1, 6, 11, 16},  b: '{1, 6, 11, 16}};
    tbl[4]  = '{a: '{0, 2, 7, 12},   b: '{0, 5, 10, 15}};
    tbl[5]  = '{a: '{0, 0, 3, 8},    b: '{0, 0, 9, 14}};
    tbl[6]  = '{a: '{0, 0, 0, 4},    b: '{0, 0, 0, 13}};
    for (int k = 7; k < 13; k++) tbl[k] = '{a: '{0, 0, 0, 0}, b: '{0, 0, 0, 0}};

    // Reset values
    #2;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_a_out", a_out, 64'd0);
    chk("rst_b_out", b_out, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_arr_clr", {63'd0, arr_clr}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back load, full wavefront, then a held-off result
    gaps = '{0, 0, 0, 0};
    load_mat(0, 100, gaps);
    run_table(0, 100);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk("hold_res_valid", {63'd0, res_valid}, 64'd1);
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      chk("hold_busy", {63'd0, busy}, 64'd0);
    end
    in_valid = 1'b0;
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    check_ack_result();

    // Load with gaps: beats on cycles 0, 3, 4, 9
    gaps = '{0, 2, 0, 4};
    load_mat(200, 300, gaps);
    run_table(200, 300);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    check_ack_result();

    // Reset during FEED step 2
    gaps = '{0, 0, 0, 0};
    load_mat(0, 100, gaps);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_a_step2", a_out, pk(5, 10, 15, 0));
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_a_out", a_out, 64'd0);
    chk("mid_rst_b_out", b_out, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh load; res_ack held high throughout must not disturb FEED/DRAIN
    res_ack = 1'b1;
    load_mat(400, 500, gaps);
    run_table(400, 500);
    @(negedge clk);
    res_ack = 1'b0;
    chk("final_res_valid", {63'd0, res_valid}, 64'd0);
    chk("final_in_ready", {63'd0, in_ready}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Skew-sequencing transmitter that drives the `a`/`b` input buses of the 4×4 `systolic_array`. It accepts operand matrices A and B one row per handshake and buffers them internally. It then emits the diagonal-skewed wavefront streams the array consumes, waits for the array to drain, and flags when the array's `result` bus holds the finished product. It sits between the operand source (DMA/register file) and `systolic_array`, replacing bench-driven skew generation.

## Interface
Parameters:
- `N`, 4, array dimension (lanes per bus, rows/cols per matrix)
- `DW`, 16, operand element width
- `DRAIN`, 4, idle cycles after the last wavefront before the result is declared valid

Ports:
- `clk`  input  1  sole clock, rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `in_valid`  input  1  load beat offered
- `in_ready`  output  1  feeder accepts a load beat
- `in_a_row`  input  N*DW  row r of A, element c at `[(c+1)*DW-1 -: DW]`
- `in_b_row`  input  N*DW  row r of B, same packing
- `a_out`  output  N*DW  to `systolic_array.a`, lane j at `[(j+1)*DW-1 -: DW]`
- `b_out`  output  N*DW  to `systolic_array.b`, lane i at `[(i+1)*DW-1 -: DW]`
- `busy`  output  1  high in FEED or DRAIN
- `res_valid`  output  1  array `result` is final
- `res_ack`  input  1  consumer has taken the result
- `arr_clr`  output  1  one-cycle clear request for the array accumulators

## Operation
- States: LOAD → FEED → DRAIN → DONE → LOAD.
- LOAD
  - `in_ready=1`.
  - Each `in_valid&in_ready` beat stores both rows at row index r. r counts 0..N-1 and is internal.
  - After beat N-1 the block goes to FEED with step s=0.
- FEED
  - Lasts 2N cycles, s=0..2N-1.
  - For step s, lane j of `a_out` = A[j+N-1-s][j] when 0≤j+N-1-s≤N-1, else 0.
  - Lane i of `b_out` = B[i][i+N-1-s] when in range, else 0.
  - Lane j is therefore nonzero for s∈[j, j+N-1].
- DRAIN
  - Lasts `DRAIN` cycles.
  - `a_out` and `b_out` are 0.
- DONE
  - `res_valid=1`, held until `res_ack`.
  - On `res_ack` the block goes to LOAD.
- `res_ack` outside DONE is ignored. `in_valid` outside LOAD is ignored because `in_ready=0`.
- Buffer: 2·N·N·DW bits of flops. It is written only in LOAD, and contents are not cleared on the DONE→LOAD transition.
- No arithmetic is performed. Data passes through unmodified, and out-of-range lanes are zero-filled.

## Timing
- Reset (async assert): state LOAD, r=0, s=0.
  - Outputs during reset: `in_ready=1`, `a_out=0`, `b_out=0`, `busy=0`, `res_valid=0`, `arr_clr=0`.
- `a_out` and `b_out` are registered.
  - Step-0 values appear in the first cycle after the edge that accepted load beat N-1.
  - Step s is held for exactly one cycle.
- `in_ready` falls in that same cycle.
- `busy` is high for 2N+DRAIN cycles: 8+4=12 with defaults.
- `res_valid` rises in the cycle after the last DRAIN cycle. Latency from the last load edge to `res_valid` is 2N+DRAIN cycles.
- On the edge where `res_valid&res_ack`: `res_valid` drops and `in_ready` rises in the next cycle.
- Back-to-back loads: a new load beat is acceptable in the first cycle `in_ready=1`.
- `rst_n` asserted mid-FEED or mid-DRAIN: outputs go to their reset values immediately (async), and the partial load or feed is discarded.

## Configuration
- `SA_FEEDER_AUTOCLR_EN`
  - Defined: `arr_clr` pulses high for exactly one cycle, the cycle after the `res_ack` handshake (coincident with `in_ready` rising). This zeroes the array accumulators before the next feed.
  - Undefined: `arr_clr` is tied 0. The integrator must reset the array by other means before reuse.

## Test plan
- Reset then load A=B=row-major 1..16 → step 0: `a_out` lane0=13, lane1..3=0; `b_out` lane0=4, others 0.
- Same load, check step 3 → `a_out` lanes {1,6,11,16}, `b_out` lanes {1,6,11,16}. Step 7 → all lanes 0.
- Integrated with `systolic_array`, A=B=1..16 → at `res_valid`, `result` rows [90 100 110 120], [202 228 254 280], [314 356 398 440], [426 484 542 600]. `res_valid` asserts 12 cycles after the last load edge.
- Hold `res_ack=0` for 5 cycles → `res_valid` stays high, `in_ready`=0, and `in_valid` pulses are not accepted. Assert `res_ack` → `in_ready`=1 next cycle, plus an `arr_clr` pulse if `SA_FEEDER_AUTOCLR_EN`.
- Drop `rst_n` at FEED step 2 → same cycle: `a_out`=`b_out`=0, `busy`=0, `in_ready`=1. A fresh 4-beat load then produces the correct step-0 pattern.
- Load with `in_valid` gaps (beats on cycles 0, 3, 4, 9) → rows stored in order, and FEED starts the cycle after the cycle-9 beat.
